// File: rtl/ex_div_ctrl.sv
// EX-stage sequencer for RV32M DIV/DIVU/REM/REMU: an iterative restoring
// divider that stalls the pipeline until the quotient or remainder is ready.
module ex_div_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

    localparam logic [WIDTH-1:0] One    = WIDTH'(1);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             sel_rem_q, sel_rem_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             is_signed, a_neg, b_neg, div_zero, ovf, special, accept, cnt_last;
    logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix, quo_spec, rem_spec;
    logic [WIDTH+1:0] rem_shift, trial;
    logic             borrow;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & a[WIDTH-1];
    assign b_neg     = is_signed & b[WIDTH-1];
    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude.
    assign a_mag     = a_neg ? (~a + One) : a;
    assign b_mag     = b_neg ? (~b + One) : b;
    assign div_zero  = (b == '0);
    assign ovf       = is_signed & (a == MinVal) & (b == '1);
    assign special   = div_zero | ovf;
    assign accept    = (state_q == StIdle) & start & ~flush;
    assign cnt_last  = (cnt_q == CNT_W'(WIDTH - 1));
    assign quo_spec  = div_zero ? '1 : MinVal;
    assign rem_spec  = div_zero ? a : '0;

    // rem_q never exceeds the divisor, so the extra top bit of trial is the borrow.
    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign trial     = rem_shift - {2'b00, dvs_q};
    assign borrow    = trial[WIDTH+1];

    assign quo_fix   = neg_q_q ? (~dvd_q + One) : dvd_q;
    assign rem_fix   = neg_r_q ? (~rem_q[WIDTH-1:0] + One) : rem_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = special ? StDone : StCalc;
            StCalc:  if (cnt_last) state_d = StFixup;
            StFixup: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_comb begin
        stall = rst_n & (accept | (state_q == StCalc) | (state_q == StFixup));
        busy  = (state_q == StCalc) | (state_q == StFixup);
        done  = (state_q == StDone);
    end

    always_comb begin
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        sel_rem_d = sel_rem_q;
        result_d  = result_q;
        if (accept) begin
            if (special) begin
                result_d = op[1] ? rem_spec : quo_spec;
            end else begin
                dvd_d     = a_mag;
                dvs_d     = b_mag;
                rem_d     = '0;
                cnt_d     = '0;
                neg_q_d   = a_neg ^ b_neg;
                neg_r_d   = a_neg;
                sel_rem_d = op[1];
            end
        end else if (state_q == StCalc) begin
            rem_d = borrow ? rem_shift[WIDTH:0] : trial[WIDTH:0];
            dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
            cnt_d = cnt_q + CNT_W'(1);
        end else if ((state_q == StFixup) && !flush) begin
            result_d = sel_rem_q ? rem_fix : quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            sel_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            sel_rem_q <= sel_rem_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed bench for ex_div_ctrl: vector table of divide ops plus flush and
// mid-operation reset sequences.
module tb_ex_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_res;

    ex_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          stl;
        int          bsy;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge, hold start until done, check timing and result.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_stl, input int exp_bsy);
        int cyc, st, bs;
        @(negedge clk);
        op = o; a = va; b = vb; start = 1'b1;
        #1;
        cyc = 0; st = 0; bs = 0;
        while (cyc < 100 && !done) begin
            if (stall) st++;
            if (busy) bs++;
            @(negedge clk);
            cyc++;
        end
        check({name, " done_seen"}, 32'(done), 32'd1);
        check({name, " latency"}, cyc, exp_lat);
        check({name, " stall_cycles"}, st, exp_stl);
        check({name, " busy_cycles"}, bs, exp_bsy);
        check({name, " result"}, result, exp_res);
        check({name, " stall_in_done"}, 32'(stall), 32'd0);
        check({name, " busy_in_done"}, 32'(busy), 32'd0);
        last_res = exp_res;
        start = 1'b0;
        @(negedge clk);
        check({name, " done_single_pulse"}, 32'(done), 32'd0);
        check({name, " idle_after"}, 32'(busy | stall), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"divu_100_7",      2'b01, 32'd100,        32'd7,          32'd14,        34, 34, 33};
        vecs[1]  = '{"rem_m7_2",        2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,  34, 34, 33};
        vecs[2]  = '{"div_m7_2",        2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,  34, 34, 33};
        vecs[3]  = '{"div_5_0",         2'b00, 32'd5,          32'd0,          32'hFFFFFFFF,  1,  1,  0};
        vecs[4]  = '{"remu_5_0",        2'b11, 32'd5,          32'd0,          32'd5,         1,  1,  0};
        vecs[5]  = '{"div_ovf",         2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,  1,  1,  0};
        vecs[6]  = '{"rem_ovf",         2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0,         1,  1,  0};
        vecs[7]  = '{"divu_max_1",      2'b01, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,  34, 34, 33};
        vecs[8]  = '{"divu_max_10",     2'b01, 32'hFFFFFFFF,   32'd10,         32'h19999999,  34, 34, 33};
        vecs[9]  = '{"remu_max_10",     2'b11, 32'hFFFFFFFF,   32'd10,         32'd5,         34, 34, 33};
        vecs[10] = '{"div_m100_m7",     2'b00, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,        34, 34, 33};
        vecs[11] = '{"rem_m100_m7",     2'b10, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,  34, 34, 33};
        vecs[12] = '{"div_min_2",       2'b00, 32'h80000000,   32'd2,          32'hC0000000,  34, 34, 33};
        vecs[13] = '{"rem_7_m2",        2'b10, 32'd7,          32'hFFFFFFFE,   32'd1,         34, 34, 33};
        vecs[14] = '{"divu_0_5",        2'b01, 32'd0,          32'd5,          32'd0,         34, 34, 33};

        rst_n = 1'b0; start = 1'b1; op = 2'b01; a = 32'd1; b = 32'd1; flush = 1'b0;
        #1;
        check("stall_during_reset", 32'(stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        last_res = 32'd0;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].lat, vecs[i].stl, vecs[i].bsy);
        end

        // flush beats start in IDLE
        @(negedge clk);
        op = 2'b01; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
        #1;
        check("idle_flush_stall", 32'(stall), 32'd0);
        @(negedge clk);
        check("idle_flush_busy", 32'(busy), 32'd0);
        check("idle_flush_done", 32'(done), 32'd0);
        start = 1'b0; flush = 1'b0;

        // flush on the 10th CALC cycle
        @(negedge clk);
        op = 2'b01; a = 32'd1000; b = 32'd10; start = 1'b1;
        @(negedge clk);
        check("flush_calc_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 9; i++) @(negedge clk);
        check("flush_10th_busy", 32'(busy), 32'd1);
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_after", 32'(busy), 32'd0);
        check("flush_stall_after", 32'(stall), 32'd0);
        check("flush_result_kept", result, last_res);
        begin
            int dn = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) dn++;
            end
            check("flush_no_done", dn, 0);
        end
        check("flush_result_kept_late", result, last_res);
        run_op("divu_9_3_after_flush", 2'b01, 32'd9, 32'd3, 32'd3, 34, 34, 33);

        // reset mid-CALC
        @(negedge clk);
        op = 2'b11; a = 32'd17; b = 32'd5; start = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_stall_low", 32'(stall), 32'd0);
        @(negedge clk);
        check("midreset_stall", 32'(stall), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_result", result, 32'd0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 32'(busy | done | stall), 32'd0);
        run_op("remu_17_5_after_reset", 2'b11, 32'd17, 32'd5, 32'd2, 34, 34, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
